// File: rtl/mem_access.sv
// Memory-access pipeline stage: IDLE/REQ/WAIT data-bus sequencer with byte/half/word lanes.
// Optional misalignment trap enabled by defining MEM_ALIGN_TRAP_EN.
module mem_access (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_rdata2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_rf_we,
    input  logic        ex_is_ram,
    input  logic        ex_ram_we,
    input  logic [1:0]  ex_mem_size,
    input  logic        ex_mem_sext,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_wdata,
    output logic [4:0]  wb_rd,
    output logic        wb_rf_we,
    output logic        mem_exc
);

    localparam int unsigned XLEN = 32;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e            state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d;
    logic              dmem_req_q, dmem_req_d;
    logic              dmem_we_q, dmem_we_d;
    logic [XLEN-1:0]   dmem_addr_q, dmem_addr_d;
    logic [3:0]        dmem_be_q, dmem_be_d;
    logic [XLEN-1:0]   dmem_wdata_q, dmem_wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic [XLEN-1:0]   wb_pc_q, wb_pc_d;
    logic [XLEN-1:0]   wb_wdata_q, wb_wdata_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic              wb_rf_we_q, wb_rf_we_d;
    logic              mem_exc_q, mem_exc_d;

    logic [XLEN-1:0]   ea_c;
    logic [3:0]        be_c;
    logic [XLEN-1:0]   st_data_c;
    logic [XLEN-1:0]   load_data_c;
    logic [7:0]        ld_byte_c;
    logic [15:0]       ld_half_c;
    logic              start_c;
    logic              complete_c;

    // Effective address with sub-size offset bits forced to zero for halves/words
    always_comb begin
        ea_c = ex_alu_out;
        if (ex_mem_size[1]) begin
            ea_c[1:0] = 2'b00;
        end else if (ex_mem_size == SZ_HALF) begin
            ea_c[0] = 1'b0;
        end
    end

`ifdef MEM_ALIGN_TRAP_EN
    logic misaligned_c;
    assign misaligned_c = (ex_mem_size[1] && (ex_alu_out[1:0] != 2'b00)) ||
                          ((ex_mem_size == SZ_HALF) && ex_alu_out[0]);
    assign start_c = ex_is_ram && !misaligned_c;
`else
    assign start_c = ex_is_ram;
`endif

    // Byte enables and replicated store data for the requested size
    always_comb begin
        case (ex_mem_size)
            SZ_BYTE: begin
                be_c      = 4'(4'b0001 << ea_c[1:0]);
                st_data_c = {4{ex_rdata2[7:0]}};
            end
            SZ_HALF: begin
                be_c      = 4'(4'b0011 << ea_c[1:0]);
                st_data_c = {2{ex_rdata2[15:0]}};
            end
            default: begin
                be_c      = 4'b1111;
                st_data_c = ex_rdata2;
            end
        endcase
    end

    // Little-endian lane select plus zero/sign extension of load data
    always_comb begin
        case (lane_q)
            2'd0:    ld_byte_c = dmem_rdata[7:0];
            2'd1:    ld_byte_c = dmem_rdata[15:8];
            2'd2:    ld_byte_c = dmem_rdata[23:16];
            default: ld_byte_c = dmem_rdata[31:24];
        endcase
        ld_half_c = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (size_q)
            SZ_BYTE: load_data_c = {{24{sext_q & ld_byte_c[7]}}, ld_byte_c};
            SZ_HALF: load_data_c = {{16{sext_q & ld_half_c[15]}}, ld_half_c};
            default: load_data_c = dmem_rdata;
        endcase
    end

    assign complete_c = ((state_q == REQ) && dmem_gnt && dmem_rvalid) ||
                        ((state_q == WAIT) && dmem_rvalid);

    assign mem_stall = ((state_q != IDLE) && !complete_c) ||
                       ((state_q == IDLE) && start_c);

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        size_d       = size_q;
        sext_d       = sext_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_be_d    = dmem_be_q;
        dmem_wdata_d = dmem_wdata_q;
        wb_valid_d   = 1'b0;
        wb_pc_d      = wb_pc_q;
        wb_wdata_d   = wb_wdata_q;
        wb_rd_d      = wb_rd_q;
        wb_rf_we_d   = wb_rf_we_q;
        mem_exc_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!ex_is_ram) begin
                    wb_valid_d = 1'b1;
                    wb_pc_d    = ex_pc;
                    wb_wdata_d = ex_alu_out;
                    wb_rd_d    = ex_rd;
                    wb_rf_we_d = ex_rf_we;
                end else if (start_c) begin
                    state_d      = REQ;
                    lane_d       = ea_c[1:0];
                    size_d       = ex_mem_size;
                    sext_d       = ex_mem_sext;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = ex_ram_we;
                    dmem_addr_d  = {ea_c[31:2], 2'b00};
                    dmem_be_d    = be_c;
                    dmem_wdata_d = st_data_c;
                end
`ifdef MEM_ALIGN_TRAP_EN
                else begin
                    wb_valid_d = 1'b1;
                    wb_pc_d    = ex_pc;
                    wb_wdata_d = ex_alu_out;
                    wb_rd_d    = ex_rd;
                    wb_rf_we_d = 1'b0;
                    mem_exc_d  = 1'b1;
                end
`endif
            end
            REQ: begin
                if (dmem_gnt) begin
                    dmem_req_d = 1'b0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                state_d = WAIT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A response retires the access (also covers grant+rvalid in REQ)
        if (complete_c) begin
            state_d    = IDLE;
            dmem_req_d = 1'b0;
            wb_valid_d = 1'b1;
            wb_pc_d    = ex_pc;
            wb_wdata_d = load_data_c;
            wb_rd_d    = ex_rd;
            wb_rf_we_d = ex_rf_we & ~dmem_we_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            lane_q       <= 2'b00;
            size_q       <= 2'b00;
            sext_q       <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_be_q    <= 4'b0000;
            dmem_wdata_q <= '0;
            wb_valid_q   <= 1'b0;
            wb_pc_q      <= '0;
            wb_wdata_q   <= '0;
            wb_rd_q      <= 5'd0;
            wb_rf_we_q   <= 1'b0;
            mem_exc_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            size_q       <= size_d;
            sext_q       <= sext_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_be_q    <= dmem_be_d;
            dmem_wdata_q <= dmem_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_pc_q      <= wb_pc_d;
            wb_wdata_q   <= wb_wdata_d;
            wb_rd_q      <= wb_rd_d;
            wb_rf_we_q   <= wb_rf_we_d;
            mem_exc_q    <= mem_exc_d;
        end
    end

    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_be    = dmem_be_q;
    assign dmem_wdata = dmem_wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_pc      = wb_pc_q;
    assign wb_wdata   = wb_wdata_q;
    assign wb_rd      = wb_rd_q;
    assign wb_rf_we   = wb_rf_we_q;
    assign mem_exc    = mem_exc_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: expected writebacks queued at drive time, popped on wb_valid.
module tb_mem_access;

    logic        clk;
    logic        resetn;
    logic [31:0] ex_pc, ex_alu_out, ex_rdata2;
    logic [4:0]  ex_rd;
    logic        ex_rf_we, ex_is_ram, ex_ram_we, ex_mem_sext;
    logic [1:0]  ex_mem_size;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        mem_stall, wb_valid, wb_rf_we, mem_exc;
    logic [31:0] wb_pc, wb_wdata;
    logic [4:0]  wb_rd;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        rf_we;
        logic        exc;
        logic        chk_data;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] fpc      = 32'h9000_0000;

    mem_access dut (
        .clk(clk), .resetn(resetn),
        .ex_pc(ex_pc), .ex_alu_out(ex_alu_out), .ex_rdata2(ex_rdata2), .ex_rd(ex_rd),
        .ex_rf_we(ex_rf_we), .ex_is_ram(ex_is_ram), .ex_ram_we(ex_ram_we),
        .ex_mem_size(ex_mem_size), .ex_mem_sext(ex_mem_sext),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_wdata(wb_wdata),
        .wb_rd(wb_rd), .wb_rf_we(wb_rf_we), .mem_exc(mem_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Writeback monitor: every wb_valid must match the oldest queued expectation
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("wb_unexpected", 32'(wb_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("wb_pc", wb_pc, e.pc);
                check("wb_rd", 32'(wb_rd), 32'(e.rd));
                check("wb_rf_we", 32'(wb_rf_we), 32'(e.rf_we));
                check("mem_exc", 32'(mem_exc), 32'(e.exc));
                if (e.chk_data) check("wb_wdata", wb_wdata, e.wdata);
            end
        end
    end

    task automatic alu(input logic [31:0] pc, input logic [31:0] val, input logic [4:0] rd,
                       input logic we, input logic push);
        ex_is_ram = 1'b0; ex_ram_we = 1'b0; ex_pc = pc; ex_alu_out = val;
        ex_rd = rd; ex_rf_we = we; ex_mem_size = 2'b10; ex_mem_sext = 1'b0;
        if (push) sb_q.push_back('{pc: pc, wdata: val, rd: rd, rf_we: we, exc: 1'b0, chk_data: 1'b1});
        @(posedge clk); #1;
    endtask

    task automatic filler(input logic push);
        fpc = fpc + 32'd4;
        alu(fpc, fpc ^ 32'h0F0F_0F0F, 5'd0, 1'b0, push);
    endtask

    // Memory op: gdly idle-grant cycles in REQ, then rvalid rdly cycles after grant
    task automatic mem_op(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] sd,
                          input logic [4:0] rd, input logic st, input logic [1:0] sz,
                          input logic sx, input int gdly, input int rdly, input logic [31:0] rdata);
        logic [31:0] ea, e_addr, e_wd, e_ld, sh;
        logic [3:0]  e_be, one_b, two_b;
        one_b = 4'b0001;
        two_b = 4'b0011;
        ea = addr;
        if (sz[1]) ea[1:0] = 2'b00;
        else if (sz == 2'b01) ea[0] = 1'b0;
        e_addr = {ea[31:2], 2'b00};
        sh = rdata >> (8 * ea[1:0]);
        case (sz)
            2'b00: begin
                e_be = one_b << ea[1:0]; e_wd = {4{sd[7:0]}};
                e_ld = sx ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
            end
            2'b01: begin
                e_be = two_b << ea[1:0]; e_wd = {2{sd[15:0]}};
                e_ld = sx ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
            end
            default: begin
                e_be = 4'hF; e_wd = sd; e_ld = rdata;
            end
        endcase
        ex_pc = pc; ex_alu_out = addr; ex_rdata2 = sd; ex_rd = rd; ex_rf_we = ~st;
        ex_is_ram = 1'b1; ex_ram_we = st; ex_mem_size = sz; ex_mem_sext = sx;
        sb_q.push_back('{pc: pc, wdata: e_ld, rd: rd, rf_we: ~st, exc: 1'b0, chk_data: ~st});
        #1 check("stall_idle", 32'(mem_stall), 32'd1);
        @(posedge clk); #1;
        for (int c = 0; c <= gdly; c++) begin
            check("req", 32'(dmem_req), 32'd1);
            check("dmem_addr", dmem_addr, e_addr);
            check("dmem_be", 32'(dmem_be), 32'(e_be));
            check("dmem_we", 32'(dmem_we), 32'(st));
            if (st) check("dmem_wdata", dmem_wdata, e_wd);
            dmem_gnt    = (c == gdly);
            dmem_rvalid = (c == gdly) && (rdly == 0);
            dmem_rdata  = rdata;
            #1 check("stall_req", 32'(mem_stall), ((c == gdly) && (rdly == 0)) ? 32'd0 : 32'd1);
            @(posedge clk); #1;
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        check("req_drop", 32'(dmem_req), 32'd0);
        for (int c = 1; c <= rdly; c++) begin
            dmem_rvalid = (c == rdly);
            dmem_rdata  = rdata;
            #1 check("stall_wait", 32'(mem_stall), (c == rdly) ? 32'd0 : 32'd1);
            @(posedge clk); #1;
            check("req_wait", 32'(dmem_req), 32'd0);
        end
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        ex_rdata2 = 32'd0;
        filler(1'b0);
        filler(1'b0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_we", 32'(dmem_we), 32'd0);
        check("rst_be", 32'(dmem_be), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_pc", wb_pc, 32'd0);
        check("rst_wb_wdata", wb_wdata, 32'd0);
        check("rst_wb_rd", 32'(wb_rd), 32'd0);
        check("rst_wb_rf_we", 32'(wb_rf_we), 32'd0);
        check("rst_mem_exc", 32'(mem_exc), 32'd0);
        resetn = 1'b1;
        filler(1'b1);

        // ALU pass-through
        alu(32'h0000_0040, 32'h0000_1234, 5'd5, 1'b1, 1'b1);
        check("alu_no_req", 32'(dmem_req), 32'd0);
        filler(1'b1);

        // LB 0x103 sext, grant cycle 1, rvalid cycle 3
        mem_op(32'h44, 32'h103, 32'd0, 5'd6, 1'b0, 2'b00, 1'b1, 0, 2, 32'h80FF_FFFF);
        filler(1'b1);
        // SH 0x202, grant delayed 3 cycles
        mem_op(32'h48, 32'h202, 32'hABCD_1234, 5'd0, 1'b1, 2'b01, 1'b0, 3, 1, 32'd0);
        filler(1'b1);
        // LW grant and rvalid together
        mem_op(32'h4C, 32'h300, 32'd0, 5'd8, 1'b0, 2'b10, 1'b0, 0, 0, 32'hDEAD_BEEF);
        // Back-to-back extra patterns: LHU, SB, LH sext
        mem_op(32'h50, 32'h402, 32'd0, 5'd9, 1'b0, 2'b01, 1'b0, 1, 1, 32'h8765_4321);
        mem_op(32'h54, 32'h101, 32'h0000_00A5, 5'd0, 1'b1, 2'b00, 1'b0, 0, 1, 32'd0);
        mem_op(32'h58, 32'h500, 32'd0, 5'd10, 1'b0, 2'b01, 1'b1, 0, 0, 32'h1234_9ABC);
        filler(1'b1);

        // Reset while in WAIT; late rvalid must be dropped
        ex_pc = 32'h60; ex_alu_out = 32'h600; ex_rd = 5'd11; ex_rf_we = 1'b1;
        ex_is_ram = 1'b1; ex_ram_we = 1'b0; ex_mem_size = 2'b10; ex_mem_sext = 1'b0;
        @(posedge clk); #1;
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        check("rstw_req_off", 32'(dmem_req), 32'd0);
        check("rstw_stall", 32'(mem_stall), 32'd1);
        resetn = 1'b0;
        filler(1'b0);
        check("rstw_wb_valid", 32'(wb_valid), 32'd0);
        check("rstw_stall_idle", 32'(mem_stall), 32'd0);
        resetn = 1'b1;
        filler(1'b1);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
        filler(1'b1);
        dmem_rvalid = 1'b0;
        check("rstw_late_req", 32'(dmem_req), 32'd0);
        filler(1'b1);

        // Misaligned LW 0x101
`ifdef MEM_ALIGN_TRAP_EN
        ex_pc = 32'h70; ex_alu_out = 32'h101; ex_rd = 5'd7; ex_rf_we = 1'b1;
        ex_is_ram = 1'b1; ex_ram_we = 1'b0; ex_mem_size = 2'b10; ex_mem_sext = 1'b0;
        sb_q.push_back('{pc: 32'h70, wdata: 32'd0, rd: 5'd7, rf_we: 1'b0, exc: 1'b1, chk_data: 1'b0});
        #1 check("trap_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        check("trap_no_req", 32'(dmem_req), 32'd0);
`else
        mem_op(32'h70, 32'h101, 32'd0, 5'd7, 1'b0, 2'b10, 1'b0, 0, 1, 32'hCAFE_F00D);
`endif
        filler(1'b1);
        filler(1'b1);
        filler(1'b0);
        #2;
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, clock; all state updates on its rising edge.
REQ-002 The block SHALL have resetn, input, 1, reset; synchronous, active-low.
REQ-003 The block SHALL have these execute-stage inputs:
- ex_pc, input, 32, instruction PC.
- ex_alu_out, input, 32, ALU result or effective address.
- ex_rdata2, input, 32, store data (rt).
- ex_rd, input, 5, destination register.
- ex_rf_we, input, 1, register-file write enable.
- ex_is_ram, input, 1, memory instruction.
- ex_ram_we, input, 1, 1=store, 0=load.
- ex_mem_size, input, 2, 00 byte, 01 half, 10 word.
- ex_mem_sext, input, 1, sign-extend loads.
REQ-004 The block SHALL have these data-bus ports:
- dmem_req, output, 1, request.
- dmem_we, output, 1, write.
- dmem_addr, output, 32, word-aligned address.
- dmem_be, output, 4, byte enables.
- dmem_wdata, output, 32, write data.
- dmem_gnt, input, 1, request accepted.
- dmem_rvalid, input, 1, response/ack.
- dmem_rdata, input, 32, read data.
REQ-005 The block SHALL have these writeback outputs:
- mem_stall, output, 1, hold upstream stages.
- wb_valid, output, 1, writeback slot valid.
- wb_pc, output, 32, PC.
- wb_wdata, output, 32, writeback data.
- wb_rd, output, 5, destination register.
- wb_rf_we, output, 1, register-file write enable.
- mem_exc, output, 1, misalignment exception.

Function
REQ-006 FSM states SHALL be IDLE, REQ and WAIT.
REQ-007 In IDLE, a non-memory op (ex_is_ram=0) SHALL register ex_pc, ex_alu_out, ex_rd and ex_rf_we to the wb_* outputs with wb_valid=1, giving 1-cycle latency.
REQ-008 In IDLE, an aligned memory op SHALL latch the address, size, sext, we and store data, and SHALL go to REQ.
REQ-009 Alignment rule: a half access SHALL be aligned when addr[0]=0; a word access SHALL be aligned when addr[1:0]=00; a byte access SHALL always be aligned.
REQ-010 In REQ, dmem_req SHALL be 1 and SHALL hold dmem_addr, dmem_we, dmem_be and dmem_wdata stable until dmem_gnt.
REQ-011 When dmem_gnt=1 in REQ, the FSM SHALL go to WAIT, and dmem_req SHALL be 0 from the next cycle.
REQ-012 If dmem_gnt and dmem_rvalid are both 1 in REQ, the access SHALL complete directly, following REQ-013.
REQ-013 When dmem_rvalid=1 in WAIT, the block SHALL write the wb_* outputs with wb_valid=1 and return to IDLE.
REQ-014 Stores SHALL also wait for dmem_rvalid, and SHALL complete with wb_rf_we=0.
REQ-015 mem_stall SHALL be combinational and SHALL equal 1 when the state is not IDLE, or when the state is IDLE with ex_is_ram=1 and an aligned access; it SHALL be 0 in the cycle dmem_rvalid is accepted.
REQ-016 Upstream SHALL hold the ex_* inputs stable while mem_stall=1; wb_valid SHALL be 0 on every stalled cycle.
REQ-017 dmem_addr SHALL equal {addr[31:2],2'b00}.
REQ-018 dmem_be SHALL be:
- byte: 4'b0001<<addr[1:0].
- half: 4'b0011<<addr[1:0].
- word: 4'b1111.
REQ-019 Store data SHALL be laid out as:
- byte: replicated {4{d[7:0]}}.
- half: replicated {2{d[15:0]}}.
- word: as-is.
REQ-020 Loads SHALL be little-endian: the block SHALL select the lane by addr[1:0], then zero-extend, or sign-extend when sext=1, to 32 bits.
REQ-021 dmem_rvalid SHALL be ignored when in IDLE (late or spurious).

Reset
REQ-022 When resetn=0 at a clock edge, the block SHALL:
- set the state to IDLE;
- drive dmem_req, dmem_we, wb_valid, wb_rf_we and mem_exc to 0;
- drive dmem_be=0 and wb_pc=wb_wdata=dmem_addr=dmem_wdata=0;
- drive wb_rd=0.
REQ-023 A reset in REQ or WAIT SHALL abandon the access with no writeback; a later dmem_rvalid SHALL be dropped per REQ-021.

Configuration
REQ-024 With MEM_ALIGN_TRAP_EN defined, a misaligned memory op in IDLE SHALL:
- issue no bus request;
- raise no stall;
- register mem_exc=1, wb_valid=1, wb_rf_we=0 and wb_pc=ex_pc for one cycle.
REQ-025 Without MEM_ALIGN_TRAP_EN, mem_exc SHALL be tied to 0, and misaligned accesses SHALL proceed with addr[1:0], or addr[0] for a half access, forced to 0.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- ALU op ex_alu_out=0x1234, rd=5, rf_we=1 -> next cycle wb_valid=1, wb_wdata=0x1234, wb_rd=5, no dmem_req.
- LB addr 0x103, sext=1; gnt cycle 1, rvalid cycle 3, rdata=0x80FFFFFF -> dmem_addr=0x100, be=0001<<3=1000, wb_wdata=0xFFFFFF80, mem_stall high until rvalid.
- SH addr 0x202, data 0xABCD1234; gnt delayed 3 cycles -> req held 4 cycles, be=1100, wdata=0x12341234, wb_rf_we=0.
- LW with gnt and rvalid in the same cycle, rdata=0xDEADBEEF -> completion in one bus cycle, wb_wdata=0xDEADBEEF.
- Reset in WAIT, rvalid arrives 2 cycles later -> wb_valid stays 0, state IDLE.
- LW addr 0x101: with MEM_ALIGN_TRAP_EN -> mem_exc=1, no req; without it -> dmem_addr=0x100, normal completion.
